// File: rtl/clk_tune_loop.sv
// clk_tune_loop: frequency-disciplining loop for the local-oscillator tune PDM.
//
// The loop counts E1 recovered-clock ticks over a window of 2^n USB SOF periods and
// compares the count with a target tick count. A PI controller then steers the 12-bit
// PDM setpoint. Firmware only configures the loop and reads its status.
//
// Optional feature: define CLK_TUNE_LOOP_HOLDOVER_EN to enable holdover. When enabled,
// a window with a zero tick count (reference lost) is not applied to the loop state.
//
// Ports:
//   i_clk, i_rst_n    system clock, asynchronous active-low reset
//   i_cfg_en          loop enable; deasserting it returns the loop to idle
//   i_cfg_win_log2    window length = 2^n SOF periods, sampled at each window start
//   i_cfg_target      expected ticks per window
//   i_cfg_kp/ki       proportional / integral arithmetic right-shifts
//   i_cfg_center      nominal PDM value
//   i_cfg_tol         lock tolerance on |error|, in ticks
//   i_tick_e1         one-cycle E1 tick strobe
//   i_tick_sof        one-cycle USB SOF strobe
//   o_pdm_val/oe      PDM setpoint and output enable
//   o_st_err          last signed error (target - count)
//   o_st_valid        one-cycle pulse per completed update
//   o_st_locked       lock flag
//   o_st_holdover     holdover flag (constant 0 without the holdover feature)
module clk_tune_loop #(
  parameter int unsigned W_CNT    = 16,
  parameter int unsigned W_PDM    = 12,
  parameter int unsigned W_INT    = 20,
  parameter int unsigned LOCK_WIN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_en,
  input  logic [2:0]       i_cfg_win_log2,
  input  logic [W_CNT-1:0] i_cfg_target,
  input  logic [3:0]       i_cfg_kp,
  input  logic [3:0]       i_cfg_ki,
  input  logic [W_PDM-1:0] i_cfg_center,
  input  logic [7:0]       i_cfg_tol,
  input  logic             i_tick_e1,
  input  logic             i_tick_sof,
  output logic [W_PDM-1:0] o_pdm_val,
  output logic             o_pdm_oe,
  output logic [W_CNT-1:0] o_st_err,
  output logic             o_st_valid,
  output logic             o_st_locked,
  output logic             o_st_holdover
);

  localparam int unsigned W_LCK = $clog2(LOCK_WIN + 1);
  localparam int unsigned W_SUM = W_INT + 2;

  localparam logic [W_LCK-1:0]        LOCK_MAX = W_LCK'(LOCK_WIN);
  localparam logic signed [W_INT:0]   INT_MAX  = {2'b00, {(W_INT-1){1'b1}}};
  localparam logic signed [W_INT:0]   INT_MIN  = -INT_MAX;
  localparam logic signed [W_SUM-1:0] PDM_MAX  = {{(W_SUM-W_PDM){1'b0}}, {W_PDM{1'b1}}};

  typedef enum logic [2:0] {StIdle, StSync, StMeas, StCalc, StUpdate} state_e;

  state_e r_state, w_state_nxt;

  // Window measurement
  logic [W_CNT-1:0] r_tick_cnt;
  logic [W_CNT-1:0] r_cnt_lat;
  logic [7:0]       r_sof_cnt;
  logic [2:0]       r_win_log2;
  logic             r_pend;

  // Controller state and outputs
  logic signed [W_CNT-1:0] r_err;
  logic signed [W_INT-1:0] r_integ;
  logic                    r_calc_hold;
  logic [W_PDM-1:0]        r_pdm_val;
  logic [W_CNT-1:0]        r_st_err;
  logic                    r_valid;
  logic [W_LCK-1:0]        r_lock_cnt;
  logic                    r_locked;
  logic                    r_holdover;

  logic                    w_counting;
  logic                    w_start;
  logic                    w_close;
  logic [7:0]              w_win_m1;
  logic [W_CNT-1:0]        w_tick_first;
  logic signed [W_CNT:0]   w_diff;
  logic signed [W_CNT-1:0] w_err_sat;
  logic signed [W_INT:0]   w_int_sum;
  logic signed [W_INT-1:0] w_int_nxt;
  logic signed [W_CNT-1:0] w_p_sh;
  logic signed [W_INT-1:0] w_i_sh;
  logic signed [W_SUM-1:0] w_sum;
  logic [W_PDM-1:0]        w_pdm_nxt;
  logic [W_CNT-1:0]        w_err_u;
  logic [W_CNT-1:0]        w_abs;
  logic                    w_in_tol;
  logic [W_LCK-1:0]        w_lock_nxt;
  logic                    w_hold_win;

  // Counting keeps running through CALC/UPDATE so no SOF is lost between windows.
  assign w_counting   = (r_state == StMeas) || (r_state == StCalc) || (r_state == StUpdate);
  assign w_start      = (r_state == StSync) && i_tick_sof;
  assign w_win_m1     = (8'd1 << r_win_log2) - 8'd1;
  assign w_close      = w_counting && i_tick_sof && (r_sof_cnt == w_win_m1);
  // A tick coincident with a window boundary belongs to the new window.
  assign w_tick_first = {{(W_CNT-1){1'b0}}, i_tick_e1};

  // ---------------------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (i_cfg_en) w_state_nxt = StSync;
      StSync:   if (i_tick_sof) w_state_nxt = StMeas;
      StMeas:   if (w_close) w_state_nxt = StCalc;
      StCalc:   w_state_nxt = StUpdate;
      // A window closing during CALC/UPDATE (very short windows) is processed straight away.
      StUpdate: w_state_nxt = (w_close || r_pend) ? StCalc : StMeas;
      default:  w_state_nxt = StIdle;
    endcase
    if (!i_cfg_en) w_state_nxt = StIdle;
  end

  // ---------------------------------------------------------------------------------------
  // Tick / SOF counters
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
      r_sof_cnt  <= '0;
      r_win_log2 <= '0;
      r_cnt_lat  <= '0;
    end else if (w_start || w_close) begin
      r_tick_cnt <= w_tick_first;
      r_sof_cnt  <= '0;
      r_win_log2 <= i_cfg_win_log2;
      if (w_close) r_cnt_lat <= r_tick_cnt;
    end else if (w_counting) begin
      if (i_tick_e1 && !(&r_tick_cnt)) r_tick_cnt <= r_tick_cnt + W_CNT'(1);
      if (i_tick_sof) r_sof_cnt <= r_sof_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------------------
  // PI datapath
  // ---------------------------------------------------------------------------------------
  assign w_diff = $signed({1'b0, i_cfg_target}) - $signed({1'b0, r_cnt_lat});

  always_comb begin
    w_err_sat = w_diff[W_CNT-1:0];
    if (w_diff[W_CNT] != w_diff[W_CNT-1]) begin
      w_err_sat = w_diff[W_CNT] ? {1'b1, {(W_CNT-1){1'b0}}} : {1'b0, {(W_CNT-1){1'b1}}};
    end
  end

  assign w_int_sum = $signed({r_integ[W_INT-1], r_integ})
                   + $signed({{(W_INT+1-W_CNT){w_err_sat[W_CNT-1]}}, w_err_sat});

  always_comb begin
    w_int_nxt = w_int_sum[W_INT-1:0];
    if (w_int_sum > INT_MAX) begin
      w_int_nxt = INT_MAX[W_INT-1:0];
    end else if (w_int_sum < INT_MIN) begin
      w_int_nxt = INT_MIN[W_INT-1:0];
    end
  end

  // UPDATE sees the error and integrator registered during CALC.
  assign w_p_sh = r_err >>> i_cfg_kp;
  assign w_i_sh = r_integ >>> i_cfg_ki;
  assign w_sum  = $signed({{(W_SUM-W_PDM){1'b0}}, i_cfg_center})
                + $signed({{(W_SUM-W_CNT){w_p_sh[W_CNT-1]}}, w_p_sh})
                + $signed({{(W_SUM-W_INT){w_i_sh[W_INT-1]}}, w_i_sh});

  always_comb begin
    w_pdm_nxt = w_sum[W_PDM-1:0];
    if (w_sum[W_SUM-1]) begin
      w_pdm_nxt = '0;
    end else if (w_sum > PDM_MAX) begin
      w_pdm_nxt = '1;
    end
  end

  assign w_err_u  = r_err;
  assign w_abs    = w_err_u[W_CNT-1] ? (~w_err_u + W_CNT'(1)) : w_err_u;
  assign w_in_tol = (w_abs <= {{(W_CNT-8){1'b0}}, i_cfg_tol});

  always_comb begin
    w_lock_nxt = '0;
    if (w_in_tol) begin
      w_lock_nxt = (r_lock_cnt == LOCK_MAX) ? LOCK_MAX : r_lock_cnt + W_LCK'(1);
    end
  end

`ifdef CLK_TUNE_LOOP_HOLDOVER_EN
  // Zero ticks in a whole window means the reference has gone away.
  assign w_hold_win = (r_cnt_lat == '0);
`else
  assign w_hold_win = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err       <= '0;
      r_integ     <= '0;
      r_calc_hold <= 1'b0;
      r_pend      <= 1'b0;
      r_pdm_val   <= '0;
      r_st_err    <= '0;
      r_valid     <= 1'b0;
      r_lock_cnt  <= '0;
      r_locked    <= 1'b0;
      r_holdover  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_pdm_val  <= i_cfg_center;
          r_integ    <= '0;
          r_lock_cnt <= '0;
          r_locked   <= 1'b0;
          r_holdover <= 1'b0;
          r_pend     <= 1'b0;
        end
        StCalc: begin
          if (i_cfg_en) begin
            if (!w_hold_win) begin
              r_err   <= w_err_sat;
              r_integ <= w_int_nxt;
            end
            r_calc_hold <= w_hold_win;
            if (w_close) r_pend <= 1'b1;
          end
        end
        StUpdate: begin
          r_pend <= 1'b0;
          if (i_cfg_en) begin
            if (r_calc_hold) begin
              r_holdover <= 1'b1;
              r_locked   <= 1'b0;
            end else begin
              r_pdm_val  <= w_pdm_nxt;
              r_st_err   <= r_err;
              r_valid    <= 1'b1;
              r_holdover <= 1'b0;
              r_lock_cnt <= w_lock_nxt;
              r_locked   <= (w_lock_nxt == LOCK_MAX);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_pdm_val     = r_pdm_val;
  assign o_pdm_oe      = w_counting;
  assign o_st_err      = r_st_err;
  assign o_st_valid    = r_valid;
  assign o_st_locked   = r_locked;
  assign o_st_holdover = r_holdover;

endmodule
